// File: rtl/rv32_dmem_arbiter.sv
// Data-memory arbiter between the RV32 MEM stage and a DMA/debug master.
// Optional DMEM_ARB_STATS_EN adds saturating stall/DMA-beat counters.
module rv32_dmem_arbiter #(
  parameter int unsigned DmaMaxWait = 4,
  parameter int unsigned LockMax    = 8
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        core_req_i,
  input  logic        core_we_i,
  input  logic [31:0] core_addr_i,
  input  logic [3:0]  core_be_i,
  input  logic [31:0] core_wdata_i,
  output logic        core_stall_o,
  output logic [31:0] core_rdata_o,
  input  logic        dma_req_i,
  input  logic        dma_we_i,
  input  logic        dma_lock_i,
  input  logic [31:0] dma_addr_i,
  input  logic [3:0]  dma_be_i,
  input  logic [31:0] dma_wdata_i,
  output logic        dma_gnt_o,
  output logic        dma_rvalid_o,
  output logic [31:0] dma_rdata_o,
  output logic [31:0] mem_addr_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [15:0] stall_cycles_o,
  output logic [15:0] dma_beats_o
`endif
);

  localparam logic [3:0] WaitMax  = 4'(DmaMaxWait);
  localparam logic [3:0] LockLast = 4'(LockMax - 1);

  typedef enum logic [0:0] {StCore, StDma} state_e;

  state_e      state_q, state_d;
  logic [3:0]  wait_q, wait_d;
  logic [3:0]  lock_q, lock_d;
  logic        rd_owner_dma_q, rd_owner_dma_d;
  logic        dma_gnt, core_gnt;

  always_comb begin
    state_d  = state_q;
    wait_d   = wait_q;
    lock_d   = lock_q;
    dma_gnt  = 1'b0;
    core_gnt = 1'b0;
    unique case (state_q)
      StCore: begin
        dma_gnt  = rst_ni & dma_req_i & (~core_req_i | (wait_q == WaitMax));
        core_gnt = rst_ni & core_req_i & ~dma_gnt;
        // lock_cnt counts burst beats including the current one; a 1-beat limit never locks
        if (dma_gnt && dma_lock_i && (LockMax > 1)) begin
          state_d = StDma;
          lock_d  = 4'd1;
        end
      end
      StDma: begin
        dma_gnt = rst_ni & dma_req_i;
        if (!dma_req_i || !dma_lock_i || (lock_q >= LockLast)) begin
          state_d = StCore;
          lock_d  = 4'd0;
        end else begin
          lock_d = lock_q + 4'd1;
        end
      end
      default: state_d = StCore;
    endcase

    if (dma_gnt || !dma_req_i) begin
      wait_d = 4'd0;
    end else if (core_gnt && (wait_q != WaitMax)) begin
      wait_d = wait_q + 4'd1;
    end

    rd_owner_dma_d = dma_gnt & ~dma_we_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= StCore;
      wait_q         <= 4'd0;
      lock_q         <= 4'd0;
      rd_owner_dma_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      wait_q         <= wait_d;
      lock_q         <= lock_d;
      rd_owner_dma_q <= rd_owner_dma_d;
    end
  end

  always_comb begin
    if (dma_gnt) begin
      mem_addr_o  = dma_addr_i;
      mem_wdata_o = dma_wdata_i;
      mem_we_o    = dma_we_i;
      mem_be_o    = dma_be_i;
    end else begin
      mem_addr_o  = core_addr_i;
      mem_wdata_o = core_wdata_i;
      mem_we_o    = core_gnt & core_we_i;
      mem_be_o    = core_gnt ? core_be_i : 4'b0000;
    end
  end

  assign dma_gnt_o    = dma_gnt;
  assign core_stall_o = rst_ni & core_req_i & ~core_gnt;
  assign dma_rvalid_o = rd_owner_dma_q;
  assign dma_rdata_o  = mem_rdata_i;
  assign core_rdata_o = mem_rdata_i;

`ifdef DMEM_ARB_STATS_EN
  logic [15:0] stall_cycles_q, stall_cycles_d;
  logic [15:0] dma_beats_q, dma_beats_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    dma_beats_d    = dma_beats_q;
    if (core_stall_o && (stall_cycles_q != 16'hFFFF)) begin
      stall_cycles_d = stall_cycles_q + 16'd1;
    end
    if (dma_gnt && (dma_beats_q != 16'hFFFF)) begin
      dma_beats_d = dma_beats_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cycles_q <= 16'd0;
      dma_beats_q    <= 16'd0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      dma_beats_q    <= dma_beats_d;
    end
  end

  assign stall_cycles_o = stall_cycles_q;
  assign dma_beats_o    = dma_beats_q;
`endif

endmodule
